// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : UART transmit path. A write-side FIFO feeds a framing FSM that
//            serialises start / data (LSB first) / optional parity / stop
//            bits. Each bit is held for SYSCLK_RATE/BAUD_RATE clocks.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
  parameter int SYSCLK_RATE = 4,
  parameter int BAUD_RATE   = 1,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 2,
  parameter int PARITY_MODE = 1,   // 0 = none, 1 = even, 2 = odd
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          SysClk,
  input  logic                          Reset,
  input  logic [DATA_BITS-1:0]          TxData,
  input  logic                          TxWrite,
  input  logic                          TxEnable,
  output logic                          TxFull,
  output logic                          TxEmpty,
  output logic [$clog2(FIFO_DEPTH):0]   TxCount,
  output logic                          TxOverflow,
  output logic                          TxBusy,
  output logic                          TxDone,
  output logic                          Tx
);

  localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0]        DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic              ODD_PARITY = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 push;
  logic                 pop;

  // Framing state
  state_t               state;
  logic [BAUD_W-1:0]    baud;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity;
  logic                 bit_end;
  logic                 frame_end;

  assign TxCount = count;
  assign TxFull  = (count == FULL_LEVEL);
  assign TxEmpty = (count == '0);

  // A write into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign push = TxWrite && !TxFull;

  assign bit_end   = (baud == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);

  // Pop from IDLE, or on the very last stop cycle so frames run back to back.
  assign pop = TxEnable && !TxEmpty && ((state == IDLE) || frame_end);

  // FIFO data array; contents need no reset because the pointers are flushed.
  always_ff @(posedge SysClk) begin
    if (push) begin
      mem[wr_ptr] <= TxData;
    end
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      TxOverflow <= 1'b0;
    end else begin
      TxOverflow <= TxWrite && TxFull;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Framing FSM. Tx/TxBusy/TxDone are registered images of the current
  // state, so the line lags the state by one clock and never sees inputs
  // combinationally.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      parity  <= 1'b0;
      Tx      <= 1'b1;
      TxBusy  <= 1'b0;
      TxDone  <= 1'b0;
    end else begin
      TxBusy <= (state != IDLE);
      TxDone <= frame_end;

      case (state)
        START:   Tx <= 1'b0;
        DATA:    Tx <= shift[0];
        PARITY:  Tx <= parity;
        default: Tx <= 1'b1;
      endcase

      if (state == IDLE || bit_end) begin
        baud <= '0;
      end else begin
        baud <= baud + 1'b1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= mem[rd_ptr];
            parity  <= (^mem[rd_ptr]) ^ ODD_PARITY;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (pop) begin
                shift  <= mem[rd_ptr];
                parity <= (^mem[rd_ptr]) ^ ODD_PARITY;
                state  <= START;
              end else begin
                state  <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
